step_arbiter: RTL and testbench
===============================

Name: step_arbiter

Overview:
- Controller and arbiter for a shared 4-bit up/down state register. This is the same style of datapath as the lab state machines: Q steps under a direction input Y.
- Two requesters each ask for a run of N steps in a chosen direction.
- The block grants the register round-robin, sequences one step per clock, and signals completion with a one-cycle done pulse.
- It sits between lab-level stimulus/control logic and the stepping datapath, which it embeds.

Parameters:
- WIDTH, 4, width of the shared state register Q.
- CNT_W, 4, width of the step-count request fields.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high for the whole transaction.
- dir0  input  1  requester 0 direction; 1 = up, 0 = down.
- steps0  input  CNT_W  requester 0 step count.
- req1  input  1  requester 1 request.
- dir1  input  1  requester 1 direction.
- steps1  input  CNT_W  requester 1 step count.
- gnt0  output  1  requester 0 owns the register.
- gnt1  output  1  requester 1 owns the register.
- busy  output  1  high in RUN or DONE.
- done  output  1  one-cycle completion pulse.
- Y  output  1  latched direction of the current or most recent transaction.
- Q  output  WIDTH  shared state register value.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, Q=0, Y=0, remaining=0, gnt0=gnt1=0, busy=0, done=0, last=1.
  - last=1 means requester 0 wins the first tie.
  - Reset asserted mid-transaction aborts immediately to these values; no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE; Q holds.
  - Exactly one req: grant it.
  - Both reqs: grant the requester not equal to last.
  - On a grant at edge k: latch dir into Y, latch steps into remaining, set gnt and last to the winner.
  - If latched steps==0, go to DONE; otherwise go to RUN.
- RUN:
  - Each edge: Q <= Q+1 if Y=1, else Q-1, modulo 2^WIDTH. Wrap-around is required: 1111+1=0000 and 0000-1=1111.
  - Each edge: remaining <= remaining-1.
  - When remaining==1 at the edge: the final step is applied and the state goes to DONE.
  - Steps=N: Q changes at edges k+1..k+N; done is high for the cycle after edge k+N; IDLE follows edge k+N+1.
- DONE: done=1, gnt held, Q holds; go to IDLE on the next edge.
- Abort: if the granted requester's req is low at an edge in RUN, go to IDLE at that edge.
  - Q is not stepped at that edge; Q keeps its value.
  - gnt clears; no done pulse.
- Requests are sampled only in IDLE.
  - The non-granted requester waits; its dir/steps are ignored until its own grant.
  - A requester still holding req when the block returns to IDLE is arbitrated again as a new transaction.
- gnt0 and gnt1 are never high together.
- busy = state is RUN or DONE.
- Y holds its value after the transaction ends.

Test Plan:
- Single up run:
  - Stimulus: reset pulse, then req0=1, dir0=1, steps0=3 from Q=0.
  - Required: gnt0 high after the grant edge; Q=1,2,3 on the next three edges; done high exactly one cycle; then IDLE with Q=3.
- Down run with wrap:
  - Stimulus: from Q=1, req1=1, dir1=0, steps1=3.
  - Required: Q=0,15,14; Y=0; gnt1 only; done pulses once.
- Simultaneous requests after reset:
  - Stimulus: req0 and req1 both high.
  - Required: requester 0 is served first; on the return to IDLE with both still high, requester 1 is granted next (round-robin alternation).
- Zero steps:
  - Stimulus: req0, steps0=0 at Q=5.
  - Required: IDLE, DONE, IDLE; Q stays 5; done pulses once; busy high for one cycle.
- Abort:
  - Stimulus: req0, dir0=1, steps0=8 from Q=0; drop req0 after Q reaches 2.
  - Required: Q freezes at 2; gnt0 falls; no done pulse; block returns to IDLE.
- Asynchronous reset mid-RUN:
  - Stimulus: assert reset between clock edges during a run.
  - Required: Q=0, gnt=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/step_arbiter.sv
// Round-robin arbiter that grants a shared up/down step register to one of two
// requesters and sequences the requested number of steps, one per clock.
module step_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             dir0,
    input  logic [CNT_W-1:0] steps0,
    input  logic             req1,
    input  logic             dir1,
    input  logic [CNT_W-1:0] steps1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             Y,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               y_q, y_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_q, last_d;
    logic               pick0, pick1;
    logic               owner_req;

    // last_q=1 means requester 1 was served last, so requester 0 wins a tie.
    assign pick0     = req0 & (~req1 | last_q);
    assign pick1     = req1 & (~req0 | ~last_q);
    assign owner_req = gnt0_q ? req0 : req1;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        y_d     = y_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
                if (pick0 || pick1) begin
                    gnt0_d = pick0;
                    gnt1_d = pick1;
                    last_d = pick1;
                    y_d    = pick1 ? dir1 : dir0;
                    rem_d  = pick1 ? steps1 : steps0;
                    busy_d = 1'b1;
                    if (rem_d == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!owner_req) begin
                    // Abort: the owner withdrew, so this edge applies no step.
                    state_d = IDLE;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    q_d   = y_q ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            y_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            y_q     <= y_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = busy_q;
    assign done = done_q;
    assign Y    = y_q;
    assign Q    = q_q;

endmodule

// File: tb/tb_step_arbiter.sv
// Directed bench for step_arbiter: each scenario task checks the packed output
// vector {gnt0,gnt1,busy,done,Y,Q} against hand-computed values.
module tb_step_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, dir0 = 1'b0, req1 = 1'b0, dir1 = 1'b0;
    logic [3:0] steps0 = '0, steps1 = '0;
    logic       gnt0, gnt1, busy, done, Y;
    logic [3:0] Q;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [8:0]  exp_v;

    step_arbiter #(.WIDTH(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .dir0(dir0), .steps0(steps0),
        .req1(req1), .dir1(dir1), .steps1(steps1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .Y(Y), .Q(Q)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pack(input logic g0, input logic g1, input logic b,
                                        input logic d, input logic y, input logic [3:0] q);
        return {g0, g1, b, d, y, q};
    endfunction

    function automatic logic [8:0] obs();
        return {gnt0, gnt1, busy, done, Y, Q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus-only helper that leaves the block in IDLE after a full run.
    task automatic prep_run(input logic who, input logic dir, input logic [3:0] n);
        if (who) begin req1 = 1'b1; dir1 = dir; steps1 = n; end
        else     begin req0 = 1'b1; dir0 = dir; steps0 = n; end
        tick();
        for (int i = 0; i < int'(n); i++) tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_v = pack(0, 0, 0, 0, 0, 4'd0);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_state: got %b want %b", obs(), exp_v); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_idle: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_up_run();
        logic [3:0] want_q [3] = '{4'd1, 4'd2, 4'd3};
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd3;
        tick();
        exp_v = pack(1, 0, 1, 0, 1, 4'd0);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL up_grant: got %b want %b", obs(), exp_v); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = pack(1, 0, 1, (i == 2), 1, want_q[i]);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL up_step%0d: got %b want %b", i, obs(), exp_v); end
        end
        req0 = 1'b0;
        tick();
        exp_v = pack(0, 0, 0, 0, 1, 4'd3);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL up_idle: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_down_wrap();
        logic [3:0] want_q [3] = '{4'd0, 4'd15, 4'd14};
        prep_run(1'b0, 1'b0, 4'd2);
        exp_v = pack(0, 0, 0, 0, 0, 4'd1);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL wrap_prep: got %b want %b", obs(), exp_v); end
        req1 = 1'b1; dir1 = 1'b0; steps1 = 4'd3;
        tick();
        exp_v = pack(0, 1, 1, 0, 0, 4'd1);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL wrap_grant: got %b want %b", obs(), exp_v); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = pack(0, 1, 1, (i == 2), 0, want_q[i]);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL wrap_step%0d: got %b want %b", i, obs(), exp_v); end
        end
        req1 = 1'b0;
        tick();
        exp_v = pack(0, 0, 0, 0, 0, 4'd14);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL wrap_idle: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd1;
        req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd1;
        tick();
        exp_v = pack(1, 0, 1, 0, 1, 4'd0);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL tie_first: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = pack(1, 0, 1, 1, 1, 4'd1);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL tie_first_done: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = pack(0, 0, 0, 0, 1, 4'd1);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL tie_idle: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = pack(0, 1, 1, 0, 1, 4'd1);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL tie_second: got %b want %b", obs(), exp_v); end
        tick();
        exp_v = pack(0, 1, 1, 1, 1, 4'd2);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL tie_second_done: got %b want %b", obs(), exp_v); end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_zero_steps();
        prep_run(1'b0, 1'b1, 4'd3);
        exp_v = pack(0, 0, 0, 0, 1, 4'd5);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL zero_prep: got %b want %b", obs(), exp_v); end
        req0 = 1'b1; dir0 = 1'b0; steps0 = 4'd0;
        tick();
        exp_v = pack(1, 0, 1, 1, 0, 4'd5);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL zero_done: got %b want %b", obs(), exp_v); end
        req0 = 1'b0;
        tick();
        exp_v = pack(0, 0, 0, 0, 0, 4'd5);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL zero_idle: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_abort();
        do_reset();
        req0 = 1'b1; dir0 = 1'b1; steps0 = 4'd8;
        tick();
        tick();
        tick();
        exp_v = pack(1, 0, 1, 0, 1, 4'd2);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL abort_pre: got %b want %b", obs(), exp_v); end
        req0 = 1'b0;
        tick();
        exp_v = pack(0, 0, 0, 0, 1, 4'd2);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL abort_stop: got %b want %b", obs(), exp_v); end
        tick();
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL abort_hold: got %b want %b", obs(), exp_v); end
    endtask

    task automatic test_async_reset();
        req1 = 1'b1; dir1 = 1'b1; steps1 = 4'd5;
        tick();
        tick();
        tick();
        exp_v = pack(0, 1, 1, 0, 1, 4'd4);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL areset_pre: got %b want %b", obs(), exp_v); end
        #2;
        reset = 1'b1;
        #1;
        exp_v = pack(0, 0, 0, 0, 0, 4'd0);
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL areset_now: got %b want %b", obs(), exp_v); end
        req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        vectors++;
        if (obs() !== exp_v) begin miscompares++; $display("FAIL areset_after: got %b want %b", obs(), exp_v); end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_wrap();
        test_tie_round_robin();
        test_zero_steps();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
